// File: rtl/truth_table_checker.sv
// truth_table_checker: clocked sweep-and-check engine for small combinational gates.
// Ports: clk/rst (sync, active-high) | start begins a sweep (IDLE only)
//        s_in   observed output of the gate under test
//        stim   vector driven onto the gate (MSB is input "a")
//        busy   sweep in progress; done one-cycle completion pulse
//        pass   last sweep had no mismatches (held until next start)
//        captured / err_count / first_err_idx  results of the last sweep
module truth_table_checker #(
    parameter int                 N_IN     = 2,
    parameter int                 SETTLE   = 1,
    parameter logic [2**N_IN-1:0] EXPECTED = 4'b0010
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 s_in,
    output logic [N_IN-1:0]      stim,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [2**N_IN-1:0]   captured,
    output logic [N_IN:0]        err_count,
    output logic [N_IN-1:0]      first_err_idx
);
    localparam int NV = 2**N_IN;
    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_SAMPLE, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [N_IN-1:0]   stim_q, stim_d, first_q, first_d;
    logic [NV-1:0]     cap_q, cap_d;
    logic [N_IN:0]     err_q, err_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              busy_q, busy_d, done_q, done_d, pass_q, pass_d;
    logic              mismatch;

    // 4-state compare so an X/Z from the gate is reported as a mismatch
    assign mismatch = (s_in !== EXPECTED[stim_q]);

    always_comb begin
        state_d = state_q;
        stim_d  = stim_q;
        first_d = first_q;
        cap_d   = cap_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        pass_d  = pass_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_SETTLE;
                    stim_d  = '0;
                    cap_d   = '0;
                    err_d   = '0;
                    first_d = '0;
                    pass_d  = 1'b0;
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                end
            end
            S_SETTLE: begin
                cnt_d   = cnt_q + 1'b1;
                state_d = (cnt_q == CW'(SETTLE - 1)) ? S_SAMPLE : S_SETTLE;
            end
            S_SAMPLE: begin
                cap_d[stim_q] = s_in;
                if (mismatch) begin
                    err_d = err_q + 1'b1;
                    if (err_q == '0) first_d = stim_q;
                end
                if (stim_q == N_IN'(NV - 1)) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    // uses the count including this final vector
                    pass_d  = (err_d == '0);
                end else begin
                    state_d = S_SETTLE;
                    stim_d  = stim_q + 1'b1;
                    cnt_d   = '0;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            stim_q  <= '0;
            first_q <= '0;
            cap_q   <= '0;
            err_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            stim_q  <= stim_d;
            first_q <= first_d;
            cap_q   <= cap_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
        end
    end

    assign stim          = stim_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign pass          = pass_q;
    assign captured      = cap_q;
    assign err_count     = err_q;
    assign first_err_idx = first_q;
endmodule

// File: tb/tb_truth_table_checker.sv
// tb_truth_table_checker: random truth tables against an arithmetic sweep model, SETTLE=1 and SETTLE=3.
module tb_truth_table_checker;
    localparam logic [3:0] EXP = 4'b0010;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [3:0] tbl = 4'b0010;

    logic [1:0] stim0, stim1, first0, first1;
    logic       busy0, busy1, done0, done1, pass0, pass1, s_in0, s_in1;
    logic [3:0] cap0, cap1;
    logic [2:0] err0, err1;

    assign s_in0 = tbl[stim0];
    assign s_in1 = tbl[stim1];

    truth_table_checker #(.N_IN(2), .SETTLE(1), .EXPECTED(EXP)) dut0 (
        .clk(clk), .rst(rst), .start(start), .s_in(s_in0), .stim(stim0), .busy(busy0),
        .done(done0), .pass(pass0), .captured(cap0), .err_count(err0), .first_err_idx(first0)
    );

    truth_table_checker #(.N_IN(2), .SETTLE(3), .EXPECTED(EXP)) dut1 (
        .clk(clk), .rst(rst), .start(start), .s_in(s_in1), .stim(stim1), .busy(busy1),
        .done(done1), .pass(pass1), .captured(cap1), .err_count(err1), .first_err_idx(first1)
    );

    int         n_checks = 0;
    int         n_pass = 0;
    int         edge_n = 0;
    bit         act[2];
    bit         swept[2];
    int         t0[2];
    logic [3:0] snap[2];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s @edge %0d: got %h want %h", tag, edge_n, obs, exp);
    endtask

    // Expected {stim,busy,done,pass,captured,err,first} k edges after the sweep's start edge:
    // each vector takes s+1 edges, so k/(s+1) vectors have been sampled.
    function automatic logic [13:0] model(input int d);
        int s, len, k, v, st, err, first;
        logic [3:0] cap;
        s = d ? 3 : 1;
        len = 4 * (s + 1);
        cap = '0;
        err = 0;
        first = 0;
        if (!swept[d]) return '0;
        k = edge_n - t0[d];
        v = k / (s + 1);
        if (v > 4) v = 4;
        st = (v > 3) ? 3 : v;
        for (int i = 0; i < v; i++) begin
            cap[i] = snap[d][i];
            if (snap[d][i] != EXP[i]) begin
                if (err == 0) first = i;
                err++;
            end
        end
        return {st[1:0], 1'(k < len), 1'(k == len), 1'(k >= len && err == 0), cap, err[2:0], first[1:0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        edge_n++;
        for (int d = 0; d < 2; d++) begin
            int len;
            len = 4 * ((d ? 3 : 1) + 1);
            if (rst) begin
                act[d] = 1'b0;
                swept[d] = 1'b0;
            end else if (start && (!act[d] || edge_n >= t0[d] + len + 2)) begin
                act[d] = 1'b1;
                swept[d] = 1'b1;
                t0[d] = edge_n;
                snap[d] = tbl;
            end
        end
        #1;
        check("dut0_outputs", {18'b0, stim0, busy0, done0, pass0, cap0, err0, first0}, {18'b0, model(0)});
        check("dut1_outputs", {18'b0, stim1, busy1, done1, pass1, cap1, err1, first1}, {18'b0, model(1)});
    endtask

    task automatic sweep(input logic [3:0] t);
        tbl = t;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (22) tick();
    endtask

    initial begin
        act = '{default: 1'b0};
        swept = '{default: 1'b0};
        t0 = '{default: 0};
        snap = '{default: 4'b0};
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
        check("reset_pass", 32'(pass0), 32'd0);

        sweep(4'b0010);
        check("good_captured", 32'(cap0), 32'h2);
        check("good_err", 32'(err0), 32'd0);
        check("good_pass", 32'(pass0), 32'd1);
        check("good_pass_s3", 32'(pass1), 32'd1);

        sweep(4'b1111);
        check("ones_err", 32'(err0), 32'd3);
        check("ones_first", 32'(first0), 32'd0);
        check("ones_pass", 32'(pass0), 32'd0);

        sweep(4'b0000);
        check("zeros_err", 32'(err0), 32'd1);
        check("zeros_first", 32'(first0), 32'd1);

        tbl = 4'($urandom);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (20) tick();

        tbl = 4'b0010;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        check("pre_reset_stim", 32'(stim0), 32'd2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_busy", 32'(busy0), 32'd0);
        check("abort_done", 32'(done0), 32'd0);
        sweep(4'b0010);
        check("after_abort_pass", 32'(pass0), 32'd1);

        tbl = 4'($urandom);
        start = 1'b1;
        repeat (20) tick();
        start = 1'b0;
        repeat (24) tick();

        repeat (6) sweep(4'($urandom));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
